// File: rtl/spi_flash_reader_pkg.sv
// Shared opcodes, command framing and controller state encoding for the SPI flash reader.
package spi_flash_reader_pkg;

    localparam logic [7:0] SPI_OP_READ = 8'h03;
    localparam logic [7:0] SPI_OP_WAKE = 8'hAB;
    localparam int CMD_BITS  = 32;
    localparam int WAKE_BITS = 8;
    localparam int BIT_CNT_W = $clog2(CMD_BITS);

    typedef enum logic [2:0] {WAKE, GAP, IDLE, CMD, DATA} state_t;

endpackage

// File: rtl/spi_flash_reader_if.sv
// Host request/response and flash pin bundle; slave = reader controller, master = host/board side.
interface spi_flash_reader_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [7:0]       data;
    logic             data_valid;
    logic             busy;
    logic             done;
    logic             spi_csb;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        output start, addr, len, abort, spi_miso,
        input  data, data_valid, busy, done, spi_csb, spi_sclk, spi_mosi
    );

    modport slave (
        input  start, addr, len, abort, spi_miso,
        output data, data_valid, busy, done, spi_csb, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_flash_reader_spi_bit_engine.sv
// SPI mode-0 bit engine: sclk = clk/2, MOSI shifted on the low phase, MISO sampled on the rising sclk edge.
module spi_bit_engine
    import spi_flash_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CMD_BITS-1:0]  load_word,
    input  logic                 run,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 bit_done,
    output logic                 byte_done,
    output logic [7:0]           rx_byte
);
    logic [CMD_BITS-1:0] tx_sh;
    logic [6:0]          rx_sh;

    // bit_done marks the high phase (bit ends at next edge); byte_done marks the edge sampling bit 7
    assign bit_done  = run & sclk;
    assign byte_done = run & ~sclk & (bit_cnt[2:0] == 3'd7);
    assign rx_byte   = {rx_sh, miso};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sclk    <= 1'b0;
            mosi    <= load_word[CMD_BITS-1];
            tx_sh   <= {load_word[CMD_BITS-2:0], 1'b0};
            bit_cnt <= '0;
        end else if (run) begin
            if (!sclk) begin
                sclk  <= 1'b1;
                rx_sh <= rx_byte[6:0];
            end else begin
                sclk    <= 1'b0;
                mosi    <= tx_sh[CMD_BITS-1];
                tx_sh   <= {tx_sh[CMD_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end else begin
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            bit_cnt <= '0;
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read controller: wakes the flash with 0xAB after reset, then serves 0x03 burst reads.
//   state | meaning
//   WAKE  | csb low, shifting the release-from-power-down opcode
//   GAP   | csb high for CS_GAP cycles between transactions
//   IDLE  | busy=0, waiting for start with nonzero len
//   CMD   | shifting {0x03, addr}
//   DATA  | receiving bytes, byte counter counts down to 1
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int CS_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    spi_flash_reader_if.slave bus
);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

    state_t               state;
    logic [LEN_W-1:0]     byte_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 csb_q, busy_q, done_q, dv_q;
    logic [7:0]           data_q;

    logic                 start_ok, wake_load, abort_ok;
    logic                 eng_load, eng_run, bit_done, byte_done;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_byte;
    logic [CMD_BITS-1:0]  load_word;
    logic                 sclk, mosi;

    assign start_ok  = (state == IDLE) && bus.start && (bus.len != '0);
    assign wake_load = (state == WAKE) && csb_q;
    assign abort_ok  = bus.abort && ((state == CMD) || (state == DATA));
    assign eng_load  = start_ok || wake_load;
    assign load_word = wake_load ? {SPI_OP_WAKE, 24'h0} : {SPI_OP_READ, bus.addr};
    // Abort stops the engine on the same edge so sclk/mosi return to 0 with csb
    assign eng_run   = !csb_q && !abort_ok &&
                       ((state == WAKE) || (state == CMD) || (state == DATA));

    spi_bit_engine u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (eng_load),
        .load_word (load_word),
        .run       (eng_run),
        .miso      (bus.spi_miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .bit_cnt   (bit_cnt),
        .bit_done  (bit_done),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAKE;
            csb_q    <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            dv_q     <= 1'b0;
            data_q   <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            dv_q   <= 1'b0;
            case (state)
                WAKE: begin
                    if (csb_q) begin
                        csb_q <= 1'b0;
                    end else if (bit_done && bit_cnt == BIT_CNT_W'(WAKE_BITS - 1)) begin
                        csb_q   <= 1'b1;
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                IDLE: begin
                    if (start_ok) begin
                        state    <= CMD;
                        busy_q   <= 1'b1;
                        csb_q    <= 1'b0;
                        byte_cnt <= bus.len;
                    end
                end
                CMD: begin
                    if (abort_ok) begin
                        csb_q   <= 1'b1;
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else if (bit_done && bit_cnt == BIT_CNT_W'(CMD_BITS - 1)) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (abort_ok) begin
                        csb_q   <= 1'b1;
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        if (byte_done) begin
                            dv_q   <= 1'b1;
                            data_q <= rx_byte;
                        end
                        if (bit_done && bit_cnt[2:0] == 3'd7) begin
                            if (byte_cnt == LEN_W'(1)) begin
                                csb_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state   <= GAP;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                byte_cnt <= byte_cnt - LEN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= WAKE;
                    csb_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.spi_csb    = csb_q;
    assign bus.spi_sclk   = sclk;
    assign bus.spi_mosi   = mosi;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.data_valid = dv_q;
    assign bus.data       = data_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash (memory[i]=i[7:0]) plus timing/data checks.
module tb_spi_flash_reader;
    localparam int LEN_W  = 8;
    localparam int CS_GAP = 4;
    localparam int BUDGET = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();
    spi_flash_reader #(.LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [23:0] i);
        return i[7:0];
    endfunction

    // Flash model: records each csb-low frame, answers 0x03 reads after a 0xAB wake.
    logic [31:0] m_sh = '0;
    int          m_bits = 0;
    int          m_out = 0;
    logic        m_miso = 1'b0;
    logic        m_csb_prev = 1'b1;
    logic        m_sclk_prev = 1'b0;
    logic        powered = 1'b0;
    int          wake_cnt = 0;
    logic [31:0] cmd_q[$];
    int          bits_q[$];
    assign bus.spi_miso = m_miso;

    always @(bus.spi_csb or bus.spi_sclk) begin
        logic [23:0] ba;
        logic [7:0]  mb;
        if (bus.spi_csb !== m_csb_prev) begin
            if (bus.spi_csb === 1'b0) begin
                m_bits = 0;
                m_out  = 0;
                m_sh   = '0;
            end else if (bus.spi_csb === 1'b1) begin
                if (m_bits == 8 && m_sh[7:0] == 8'hAB) begin
                    powered = 1'b1;
                    wake_cnt++;
                end
                cmd_q.push_back(m_sh);
                bits_q.push_back(m_bits);
            end
        end
        if (bus.spi_sclk !== m_sclk_prev && bus.spi_csb === 1'b0) begin
            if (bus.spi_sclk === 1'b1) begin
                if (m_bits < 32) m_sh = {m_sh[30:0], bus.spi_mosi};
                m_bits++;
            end else if (m_bits >= 32 && powered && m_sh[31:24] == 8'h03) begin
                ba     = m_sh[23:0] + 24'(m_out / 8);
                mb     = mem_byte(ba);
                m_miso = mb[7 - (m_out % 8)];
                m_out++;
            end
        end
        m_csb_prev  = bus.spi_csb;
        m_sclk_prev = bus.spi_sclk;
    end

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         done_cyc[$];
    int         low_q[$];
    int         rise_q[$];
    int         low_run = 0;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(bus.data);
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
        if (bus.spi_csb === 1'b0) begin
            low_run++;
        end else if (low_run > 0) begin
            low_q.push_back(low_run);
            rise_q.push_back(cyc);
            low_run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int t_idle, output bit ok);
        int to = 0;
        while (bus.busy !== 1'b0 && to < BUDGET) begin
            @(posedge clk); #1;
            to++;
        end
        t_idle = cyc;
        ok = (to < BUDGET);
    endtask

    // abort_at: -1 none, 0 abort together with start, >0 abort during cycle t0+abort_at.
    // extra_at: >0 pulses a second start while busy during cycle t0+extra_at.
    task automatic do_read(input logic [23:0] a, input int n, input int abort_at, input int extra_at);
        int t0, t_idle, to, nv, dv0, dn0, cq0, lq0;
        logic csb_ab, sclk_ab, mosi_ab;
        dv0 = dv_cyc.size(); dn0 = done_cyc.size(); cq0 = cmd_q.size(); lq0 = low_q.size();
        csb_ab = 1'bx; sclk_ab = 1'bx; mosi_ab = 1'bx;
        @(posedge clk); #1;
        t0 = cyc;
        bus.addr  = a;
        bus.len   = LEN_W'(n);
        bus.start = 1'b1;
        bus.abort = (abort_at == 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        to = 0;
        while (bus.busy !== 1'b0 && to < BUDGET) begin
            if (abort_at > 0 && cyc == t0 + abort_at + 1) begin
                csb_ab = bus.spi_csb; sclk_ab = bus.spi_sclk; mosi_ab = bus.spi_mosi;
            end
            bus.abort = (abort_at > 0 && cyc == t0 + abort_at);
            if (extra_at > 0 && cyc == t0 + extra_at) begin
                bus.start = 1'b1;
                bus.addr  = 24'($urandom);
                bus.len   = LEN_W'(2);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            to++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        t_idle = cyc;
        check("rd_timeout", to < BUDGET, 1);

        nv = n;
        if (abort_at > 0) begin
            nv = 0;
            for (int k = 0; k < n; k++) if (80 + 16 * k <= abort_at) nv++;
        end
        check("dv_count", dv_cyc.size() - dv0, nv);
        for (int k = 0; k < nv && dv0 + k < dv_cyc.size(); k++) begin
            check("dv_cycle", dv_cyc[dv0 + k] - t0, 80 + 16 * k);
            check("dv_data", dv_dat[dv0 + k], mem_byte(a + 24'(k)));
        end
        check("csb_frames", low_q.size() - lq0, 1);
        if (abort_at > 0) begin
            check("abort_done", done_cyc.size() - dn0, 0);
            check("abort_csb", csb_ab, 1);
            check("abort_sclk", sclk_ab, 0);
            check("abort_mosi", mosi_ab, 0);
            check("abort_busy_fall", t_idle - t0, abort_at + 1 + CS_GAP);
        end else begin
            check("done_count", done_cyc.size() - dn0, 1);
            check("done_cycle", (done_cyc.size() > dn0) ? done_cyc[dn0] - t0 : -1, 65 + 16 * n);
            check("busy_fall", t_idle - t0, 65 + 16 * n + CS_GAP);
        end
        if (abort_at <= 0 || abort_at >= 65) begin
            check("cmd_frames", cmd_q.size() - cq0, 1);
            check("cmd_word", (cmd_q.size() > cq0) ? cmd_q[cq0] : 32'hx, {8'h03, a});
        end
    endtask

    initial begin
        int   t_idle, r, t0, w0, lq0, dn0;
        bit   ok;
        logic busy_seen;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.addr  = '0;
        bus.len   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_csb", bus.spi_csb, 1);
        check("rst_sclk", bus.spi_sclk, 0);
        check("rst_mosi", bus.spi_mosi, 0);
        check("rst_data", bus.data, 0);
        check("rst_dv", bus.data_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 1);

        lq0 = low_q.size();
        rst_n = 1'b1;
        r = cyc;
        wait_idle(t_idle, ok);
        check("wake_timeout", ok, 1);
        check("wake_len", (low_q.size() > lq0) ? low_q[lq0] : -1, 16);
        check("wake_start", (rise_q.size() > lq0) ? rise_q[lq0] - 16 : -1, r + 1);
        check("wake_gap", (rise_q.size() > lq0) ? t_idle - rise_q[lq0] : -1, CS_GAP);
        check("wake_bits", bits_q[bits_q.size() - 1], 8);
        check("wake_word", cmd_q[cmd_q.size() - 1] & 32'hFF, 32'hAB);
        check("powered", powered, 1);

        do_read(24'h000010, 4, -1, 0);
        do_read(24'hFFFFFE, 3, -1, 0);
        for (int i = 0; i < 3; i++) do_read(24'($urandom), $urandom_range(1, 5), -1, 0);
        do_read(24'h000010, 8, 90, 0);
        do_read(24'($urandom), 2, 0, 0);
        do_read(24'($urandom), 3, -1, 20);
        do_read(24'($urandom), 2, -1, 70);
        do_read(24'($urandom), 4, $urandom_range(2, 60), 0);

        // len=0 start and a lone abort in IDLE must both be ignored
        lq0 = low_q.size();
        dn0 = done_cyc.size();
        busy_seen = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = '0; bus.addr = 24'h123456;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b1;
        if (bus.busy !== 1'b0) busy_seen = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        repeat (40) begin
            if (bus.busy !== 1'b0 || bus.spi_csb !== 1'b1) busy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("len0_quiet", busy_seen, 0);
        check("len0_frames", low_q.size() - lq0, 0);
        check("len0_done", done_cyc.size() - dn0, 0);

        // reset in the middle of DATA while sclk is high
        w0 = wake_cnt;
        @(posedge clk); #1;
        t0 = cyc;
        bus.addr = 24'h000100; bus.len = LEN_W'(8); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cyc < t0 + 100) begin
            @(posedge clk); #1;
        end
        check("pre_rst_sclk", bus.spi_sclk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_csb", bus.spi_csb, 1);
        check("midrst_sclk", bus.spi_sclk, 0);
        check("midrst_busy", bus.busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(t_idle, ok);
        check("rewake_timeout", ok, 1);
        check("rewake_cnt", wake_cnt - w0, 1);
        do_read(24'($urandom), 3, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Master-side controller that sequences an external serial SPI flash for the VGA datapath. It wakes the flash after reset with 0xAB, then serves burst reads.
- A burst is opcode 0x03, a 24-bit address, then N data bytes, delivered as a byte stream with a valid strobe.
- Single-bit SPI mode 0. SCLK = clk/2, generated by the controller. No backpressure: the consumer must accept every byte.

Parameters:
LEN_W, 8, width of burst-length input; legal len 1..2^LEN_W-1
CS_GAP, 4, clk cycles CSB is held high between transactions (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request; sampled only when busy=0
addr  in  24  flash byte address, captured with start
len  in  LEN_W  byte count, captured with start
abort  in  1  terminate current read transaction
data  out  8  received byte, MSB-first assembled
data_valid  out  1  1-cycle strobe, data valid
busy  out  1  high from reset/start until back in IDLE
done  out  1  1-cycle pulse at normal end of a read burst
spi_csb  out  1  flash chip select, active low
spi_sclk  out  1  flash clock
spi_mosi  out  1  flash io0
spi_miso  in  1  flash io1

Behaviour:
- Reset (async, immediate): spi_csb=1, spi_sclk=0, spi_mosi=0, data=0, data_valid=0, done=0, busy=1, state=WAKE. All counters are cleared.
- States: WAKE -> GAP -> IDLE -> CMD -> DATA -> GAP -> IDLE.
- Bit timing, all outputs registered:
  - Each SPI bit takes 2 clk cycles: a low phase (sclk=0, mosi updated) then a high phase (sclk=1).
  - MISO is sampled at the clk edge where sclk goes 0->1.
  - mosi changes only while sclk=0 or the edge sclk goes 1->0.
- WAKE: from the first edge after rst_n rises, csb=0 and 0xAB is shifted MSB first (16 cycles). Then csb=1 and the block enters GAP.
- GAP: csb=1, sclk=0 for CS_GAP cycles, then IDLE.
- IDLE: busy=0.
  - start with len!=0: capture addr/len; next cycle (t0+1) busy=1, csb=0, state CMD.
  - start with len=0 is ignored: no transaction, no done.
- CMD: shifts 32 bits {0x03, addr[23:0]} MSB first. Bit k occupies cycles t0+1+2k (low) and t0+2+2k (high).
- DATA:
  - Byte n bit j is sampled at the edge starting cycle t0+66+16n+2j.
  - data and data_valid are updated on the edge of bit 7, so byte n is valid in cycle t0+80+16n.
  - sclk keeps toggling.
- End of burst: after the high phase of the last byte's bit 7, csb=1 and done=1 for 1 cycle (cycle t0+65+16*len). Then GAP, then IDLE.
- abort (CMD or DATA):
  - Next cycle csb=1, sclk=0, mosi=0.
  - No further data_valid; a byte in progress is discarded; no done. Then GAP.
  - abort in IDLE/GAP/WAKE is ignored.
- start while busy=1 is ignored (no queueing). start and abort together in IDLE: start wins.
- Address wrap is the flash's concern; the controller sends addr unchanged.
- Byte counter counts down from len; the last byte is detected at count==1.
- Mid-operation reset: csb rises asynchronously and the WAKE sequence repeats.

Decomposition:
- Shared package holds:
  - opcodes SPI_OP_READ=8'h03 and SPI_OP_WAKE=8'hAB
  - the state enum {WAKE, GAP, IDLE, CMD, DATA}
  - CMD_BITS=32
- One sub-module is natural: spi_bit_engine. It owns the sclk phase toggle, 32-bit MOSI shift register, 8-bit MISO shift register and bit counter, with load/run/bit_done/byte_done handshakes.
- The top-level FSM, byte counter and GAP timer stay in spi_flash_reader.

Test Plan:
- Bench wiring: spiflash model loaded with bytes memory[i]=i[7:0].
- Reset release -> csb low 16 cycles, MOSI carries 0xAB, csb high CS_GAP cycles, then busy=0. The model reports powered-up.
- start addr=0x000010 len=4 at t0 -> MOSI 0x03,0x00,0x00,0x10; data_valid at t0+80/96/112/128 with data 0x10,0x11,0x12,0x13; done at t0+129; busy falls CS_GAP cycles later.
- start addr=0xFFFFFE len=3 -> bytes memory[FFFFFE], memory[FFFFFF], memory[000000]; done pulses once.
- abort asserted at t0+90 during len=8 burst -> exactly 1 data_valid (0x10 at t0+80), csb high at t0+91, no done; the next start reads correctly.
- start pulsed while busy, and start with len=0 in IDLE -> both ignored: no csb activity, no done.
- rst_n pulsed low mid-DATA -> csb=1 and sclk=0 immediately; WAKE repeats; a following read returns correct data.
